// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_ring family: pointer wrap-around and width sizing.
// Kept free of power-of-2 assumptions so any DEPTH >= 2 works.
package fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Compare-and-wrap rather than masking, so non-power-of-2 depths wrap correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer for fifo_ring: counts 0..DEPTH-1 and returns to 0.
// Used once for the read side and once for the write side.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PW'(ptr_next(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_ring.sv
// Parametrised single-clock FIFO with fill count, threshold flags, sticky error flags
// and a circular mode in which every pop re-appends the popped (or replacement) word.
module fifo_ring
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 4,
    parameter bit          FWFT          = 1'b1,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CW = cnt_width(DEPTH),
    localparam int unsigned PW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             circular,
    input  logic             write,
    input  logic [WIDTH-1:0] datain,
    input  logic             read,
    output logic [WIDTH-1:0] dataout,
    output logic             dataout_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_err
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             rd_ok;
    logic             circ_pop;
    logic             wr_ok;
    logic             mem_we;
    logic             ovf_ev;
    logic             unf_ev;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] mem_wdata;

    assign head = mem[rd_ptr];

    always_comb begin
        rd_ok    = read & ~empty_q;
        circ_pop = circular & rd_ok;
        // In a circular pop the write port only selects the replacement word.
        wr_ok    = write & (~full_q | rd_ok) & ~circ_pop;
        mem_we   = wr_ok | circ_pop;
        mem_wdata = (circ_pop & ~write) ? head : datain;
        ovf_ev   = write & ~wr_ok & ~circ_pop;
        unf_ev   = read & empty_q;

        count_d = count_q;
        if (!circ_pop) begin
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        aempty_d = (32'(count_d) <= AEMPTY_THRESH);
        afull_d  = (32'(count_d) >= AFULL_THRESH);

        // A new error on the same edge as clear_err keeps the flag set.
        overflow_d  = (overflow_q & ~clear_err) | ovf_ev;
        underflow_d = (underflow_q & ~clear_err) | unf_ev;
    end

    fifo_ptr #(
        .DEPTH(DEPTH)
    ) u_rd_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (rd_ok),
        .ptr  (rd_ptr)
    );

    fifo_ptr #(
        .DEPTH(DEPTH)
    ) u_wr_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (mem_we),
        .ptr  (wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[wr_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            aempty_q    <= aempty_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    generate
        if (FWFT) begin : g_fwft
            assign dataout       = empty_q ? '0 : head;
            assign dataout_valid = ~empty_q;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            logic             dvalid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_ok;
                    if (rd_ok) begin
                        dout_q <= head;
                    end
                end
            end

            assign dataout       = dout_q;
            assign dataout_valid = dvalid_q;
        end
    endgenerate

endmodule
